// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: runs one MULT/DIV on the shared iterative units.
// Ports: req_valid/req_op in, req_ready/busy out; mult/div start
// pulses out and stop/div_zero flags in; sel_mux_hi/lo and HiLo_load
// steer and load Hi/Lo; done, exc_div_zero and exc_timeout are
// one-cycle result pulses; cycle_count holds the last WAIT length.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_op,
  output logic             req_ready,
  output logic             busy,
  output logic             mult_control,
  output logic             div_control,
  input  logic             mult_stop,
  input  logic             div_stop,
  input  logic             div_zero,
  output logic             sel_mux_hi,
  output logic             sel_mux_lo,
  output logic             HiLo_load,
  output logic             done,
  output logic             exc_div_zero,
  output logic             exc_timeout,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_LOAD,
    S_DONE,
    S_EXC
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic             op;
  logic [CNT_W-1:0] cnt;
  logic             stop_sel;

  // Only the selected unit's stop flag matters.
  assign stop_sel = op ? div_stop : mult_stop;

  // All outputs are registered and set together with the next state,
  // so each output already reflects the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      op           <= 1'b0;
      cnt          <= '0;
      cycle_count  <= '0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      mult_control <= 1'b0;
      div_control  <= 1'b0;
      sel_mux_hi   <= 1'b0;
      sel_mux_lo   <= 1'b0;
      HiLo_load    <= 1'b0;
      done         <= 1'b0;
      exc_div_zero <= 1'b0;
      exc_timeout  <= 1'b0;
    end else begin
      mult_control <= 1'b0;
      div_control  <= 1'b0;
      HiLo_load    <= 1'b0;
      done         <= 1'b0;
      exc_div_zero <= 1'b0;
      exc_timeout  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            state        <= S_START;
            op           <= req_op;
            mult_control <= ~req_op;
            div_control  <= req_op;
            sel_mux_hi   <= ~req_op;
            sel_mux_lo   <= ~req_op;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // div-zero beats stop; stop beats timeout
          if (op && div_zero) begin
            state        <= S_EXC;
            exc_div_zero <= 1'b1;
          end else if (stop_sel) begin
            state       <= S_LOAD;
            HiLo_load   <= 1'b1;
            cycle_count <= cnt + 1'b1;
          end else if (cnt == LAST) begin
            state       <= S_EXC;
            exc_timeout <= 1'b1;
          end
        end
        S_LOAD: begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE, S_EXC: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          sel_mux_hi <= 1'b0;
          sel_mux_lo <= 1'b0;
        end
        default: begin
          state      <= S_IDLE;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          sel_mux_hi <= 1'b0;
          sel_mux_lo <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for muldiv_sequencer.
// Per-cycle table plus timeout and async-reset sequences.
module tb_muldiv_sequencer;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_op;
  logic       req_ready;
  logic       busy;
  logic       mult_control;
  logic       div_control;
  logic       mult_stop;
  logic       div_stop;
  logic       div_zero;
  logic       sel_mux_hi;
  logic       sel_mux_lo;
  logic       HiLo_load;
  logic       done;
  logic       exc_div_zero;
  logic       exc_timeout;
  logic [5:0] cycle_count;

  muldiv_sequencer #(
    .TIMEOUT_CYCLES(40),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_ready(req_ready),
    .busy(busy),
    .mult_control(mult_control),
    .div_control(div_control),
    .mult_stop(mult_stop),
    .div_stop(div_stop),
    .div_zero(div_zero),
    .sel_mux_hi(sel_mux_hi),
    .sel_mux_lo(sel_mux_lo),
    .HiLo_load(HiLo_load),
    .done(done),
    .exc_div_zero(exc_div_zero),
    .exc_timeout(exc_timeout),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ready, busy, mctl, dctl, sel_hi, sel_lo, load, done, ezero, etime}
  localparam logic [9:0] IDLE = 10'b1000000000;
  localparam logic [9:0] S_M  = 10'b0110110000;
  localparam logic [9:0] W_M  = 10'b0100110000;
  localparam logic [9:0] L_M  = 10'b0100111000;
  localparam logic [9:0] D_M  = 10'b0100110100;
  localparam logic [9:0] ET_M = 10'b0100110001;
  localparam logic [9:0] S_D  = 10'b0101000000;
  localparam logic [9:0] W_D  = 10'b0100000000;
  localparam logic [9:0] L_D  = 10'b0100001000;
  localparam logic [9:0] D_D  = 10'b0100000100;
  localparam logic [9:0] EZ_D = 10'b0100000010;

  typedef struct {
    logic       rv;
    logic       op;
    logic       ms;
    logic       ds;
    logic       dz;
    logic [9:0] exp;
    logic [5:0] cc;
  } vec_t;

  vec_t vecs[20];
  int   errors = 0;
  int   checks = 0;
  logic [9:0] outs;

  assign outs = {req_ready, busy, mult_control, div_control,
                 sel_mux_hi, sel_mux_lo, HiLo_load, done,
                 exc_div_zero, exc_timeout};

  task automatic check(input string name,
                       input logic [9:0] exp,
                       input logic [5:0] cc);
    checks++;
    if (outs !== exp || cycle_count !== cc) begin
      errors++;
      $display("FAIL %s: got outs=%b cc=%0d, want outs=%b cc=%0d",
               name, outs, cycle_count, exp, cc);
    end
  endtask

  task automatic drive(input logic rv, input logic op,
                       input logic ms, input logic ds,
                       input logic dz);
    req_valid = rv;
    req_op    = op;
    mult_stop = ms;
    div_stop  = ds;
    div_zero  = dz;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse outputs must be mutually exclusive in every cycle.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ($countones({mult_control, div_control, HiLo_load, done,
                      exc_div_zero, exc_timeout}) > 1) begin
        errors++;
        $display("FAIL onehot: got pulses=%b, want at most one set",
                 {mult_control, div_control, HiLo_load, done,
                  exc_div_zero, exc_timeout});
      end
    end
  end

  initial begin
    // MULT, stop in 3rd WAIT; busy requests and div_stop ignored
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_M,  6'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W_M,  6'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, W_M,  6'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, W_M,  6'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, L_M,  6'd3};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, D_M,  6'd3};
    // request held through DONE then IDLE: accepted from IDLE
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 6'd3};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_D,  6'd3};
    // DIV, stop in 5th WAIT; mult_stop ignored
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W_D,  6'd3};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, W_D,  6'd3};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W_D,  6'd3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W_D,  6'd3};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W_D,  6'd3};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, L_D,  6'd5};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, D_D,  6'd5};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 6'd5};
    // divide by zero together with div_stop in 1st WAIT
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, S_D,  6'd5};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W_D,  6'd5};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, EZ_D, 6'd5};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 6'd5};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset", IDLE, 6'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    check("idle", IDLE, 6'd0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rv, vecs[i].op, vecs[i].ms,
            vecs[i].ds, vecs[i].dz);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].cc);
    end

    // timeout: MULT never stops, stray div_stop mid-WAIT
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("to_start", S_M, 6'd5);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    for (int k = 1; k <= 40; k++) begin
      check($sformatf("to_wait%0d", k), W_M, 6'd5);
      div_stop = (k == 20);
      step();
    end
    check("to_exc", ET_M, 6'd5);
    div_stop = 1'b0;
    step();
    check("to_idle", IDLE, 6'd5);

    // async reset in WAIT
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("rst_wait2", W_M, 6'd5);
    #2;
    reset     = 1'b1;
    mult_stop = 1'b1;
    #1;
    check("rst_async", IDLE, 6'd0);
    step();
    check("rst_hold1", IDLE, 6'd0);
    step();
    check("rst_hold2", IDLE, 6'd0);
    @(negedge clk);
    reset     = 1'b0;
    mult_stop = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("post_start", S_M, 6'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("post_wait1", W_M, 6'd0);
    mult_stop = 1'b1;
    step();
    check("post_load", L_M, 6'd1);
    mult_stop = 1'b0;
    step();
    check("post_done", D_M, 6'd1);
    step();
    check("post_idle", IDLE, 6'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Sequences the shared iterative mult and div units for the multi-cycle control unit. Accepts one MULT/DIV request, pulses the selected unit's start line and waits for its stop flag. On completion it steers the Hi/Lo select muxes and pulses HiLo_load. It also detects divide-by-zero and hung-unit timeout, and reports them to the control unit as exception pulses.

Parameters:
TIMEOUT_CYCLES, 40, max WAIT cycles before a timeout exception (must be >= 2).
CNT_W, 6, width of cycle counter and cycle_count (2^CNT_W > TIMEOUT_CYCLES).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  control unit requests an operation.
req_op  in  1  0 = MULT, 1 = DIV; sampled with req_valid.
req_ready  out  1  high only in IDLE.
busy  out  1  high in every state except IDLE.
mult_control  out  1  one-cycle start pulse to mult.
div_control  out  1  one-cycle start pulse to div.
mult_stop  in  1  mult finished; Hi/Lo outputs valid.
div_stop  in  1  div finished; Hi/Lo outputs valid.
div_zero  in  1  divisor is zero, from div.
sel_mux_hi  out  1  Hi mux select: 0 = div result, 1 = mult result.
sel_mux_lo  out  1  Lo mux select, same encoding as sel_mux_hi.
HiLo_load  out  1  one-cycle load enable for Hi and Lo.
done  out  1  one-cycle pulse; the operation completed normally.
exc_div_zero  out  1  one-cycle pulse; divide by zero.
exc_timeout  out  1  one-cycle pulse; the selected unit never stopped.
cycle_count  out  CNT_W  number of WAIT cycles of the last normally completed operation.

Behaviour:
- Reset (async, active-high): state = IDLE. All outputs are 0 except req_ready = 1. Internal op register = 0, counter = 0, cycle_count = 0.
- States: IDLE, START, WAIT, LOAD, DONE, EXC.
- IDLE: req_ready = 1. If req_valid = 1, latch op = req_op, then go to START. Otherwise stay in IDLE.
- START: assert mult_control (op = 0) or div_control (op = 1) for exactly this one cycle. Clear the counter, then go to WAIT.
- WAIT: the counter increments each cycle. Evaluate in this priority order:
  - op = 1 and div_zero = 1: go to EXC with cause div-zero.
  - Stop flag of the selected unit = 1: go to LOAD; cycle_count <= counter + 1.
  - counter == TIMEOUT_CYCLES - 1: go to EXC with cause timeout.
  - Otherwise stay in WAIT.
- The stop flag of the non-selected unit is ignored.
- LOAD: HiLo_load = 1 for one cycle, then go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE.
- EXC: pulse exc_div_zero or exc_timeout (exactly one) for one cycle. HiLo_load stays 0, so Hi and Lo are unchanged. Then go to IDLE.
- sel_mux_hi = sel_mux_lo = ~op in every state except IDLE, and 0 in IDLE. They are stable during LOAD.
- Latency: request accepted on edge 0. START runs in cycle 1. WAIT starts in cycle 2. If stop is first seen in WAIT cycle n (n >= 1), LOAD follows at cycle 2+n and done at cycle 3+n.
- req_valid while busy is ignored (no queueing). A new request can be accepted in the IDLE cycle after DONE or EXC.
- Simultaneous events:
  - div_zero and div_stop together: div-zero exception wins.
  - stop and timeout in the same cycle: normal completion wins.
- Reset mid-operation: immediate return to IDLE, no done, no exception pulse, no HiLo_load.
- At most one of mult_control, div_control, HiLo_load, done, exc_div_zero, exc_timeout is high in any cycle.

Test Plan:
- MULT: req_valid = 1, req_op = 0 for one cycle; mult_stop rises in the 3rd WAIT cycle -> mult_control pulses once, sel_mux_hi/lo = 1, HiLo_load pulses one cycle before done, cycle_count = 3.
- DIV normal: req_op = 1; div_stop in the 5th WAIT cycle -> div_control pulses once, sel = 0, HiLo_load then done, cycle_count = 5.
- Divide by zero: req_op = 1; div_zero = 1 in the 1st WAIT cycle, together with div_stop -> exc_div_zero pulses, HiLo_load never asserts, cycle_count unchanged, req_ready returns next cycle.
- Timeout with TIMEOUT_CYCLES = 40: mult_stop never asserts -> exc_timeout pulses after exactly 40 WAIT cycles. A div_stop pulse injected mid-WAIT is ignored.
- Back-to-back and busy: a second req_valid held during an active MULT is ignored; a request held through IDLE after done is accepted, and its start pulse comes the cycle after acceptance.
- Async reset in WAIT: assert reset mid-cycle -> outputs clear immediately with no clock edge needed, and no done or HiLo_load occurs. After release, a new MULT completes normally.
